// File: rtl/issue_buffer.sv
// In-order issue buffer between decode and scoreboard; holds issue after a control-flow
// instruction until it resolves. Optional combinational bypass: ISSUE_BUFFER_BYPASS_EN.
module issue_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     flush_unissued_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     valid_i,
  input  logic                     is_ctrl_flow_i,
  output logic                     ack_o,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     valid_o,
  input  logic                     ack_i,
  input  logic                     resolve_branch_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   usage_o
);

  localparam int PW = $clog2(DEPTH);

  // Handshake: a transfer happens on a cycle where both sides' valid and ack/ready are high;
  // valid never depends on the same side's ack, and held data stays stable until taken.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      ctrl_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           count_q;
  logic                  lock_q;

  logic head_valid, push, pop, issue_ctrl, issued, flushing;

  assign full_o     = (count_q == (PW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign usage_o    = count_q;
  assign flushing   = flush_i || flush_unissued_i;
  assign ack_o      = !full_o && !flushing;
  assign head_valid = !empty_o && !lock_q;
  assign pop        = head_valid && ack_i;
  assign issued     = valid_o && ack_i;

`ifdef ISSUE_BUFFER_BYPASS_EN
  logic bypass_active;
  assign bypass_active = empty_o && !lock_q && !flushing;
  assign valid_o       = bypass_active ? valid_i : head_valid;
  assign data_o        = bypass_active ? data_i : mem_q[rd_ptr_q];
  assign issue_ctrl    = bypass_active ? is_ctrl_flow_i : ctrl_q[rd_ptr_q];
  // A bypassed entry consumed in the same cycle never occupies a slot.
  assign push          = valid_i && ack_o && !(bypass_active && ack_i);
`else
  assign valid_o       = head_valid;
  assign data_o        = mem_q[rd_ptr_q];
  assign issue_ctrl    = ctrl_q[rd_ptr_q];
  assign push          = valid_i && ack_o;
`endif

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q]  <= data_i;
      ctrl_q[wr_ptr_q] <= is_ctrl_flow_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flushing) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + (PW+1)'(1);
      else if (pop && !push) count_q <= count_q - (PW+1)'(1);
    end
  end

  // Issuing a new branch wins over a coincident resolve: only one branch may be outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                   lock_q <= 1'b0;
    else if (flush_i)              lock_q <= 1'b0;
    else if (issued && issue_ctrl) lock_q <= 1'b1;
    else if (resolve_branch_i)     lock_q <= 1'b0;
  end

endmodule

// File: tb/tb_issue_buffer.sv
// Bench for issue_buffer: vector table with per-cycle expected flags, a data scoreboard,
// and directed reset / bypass sequences.
module tb_issue_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, flush_unissued_i;
  logic [63:0] data_i;
  logic        valid_i, is_ctrl_flow_i;
  logic        ack_o;
  logic [63:0] data_o;
  logic        valid_o, ack_i, resolve_branch_i;
  logic        full_o, empty_o;
  logic [2:0]  usage_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        vld;
    logic [63:0] d;
    logic        c, ak, rs, fl, fu;
    logic        ev, ea;
    logic [2:0]  eu;
  } vec_t;

  vec_t tbl[$];

  issue_buffer #(.DEPTH(4), .DATA_WIDTH(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_unissued_i(flush_unissued_i),
    .data_i(data_i), .valid_i(valid_i), .is_ctrl_flow_i(is_ctrl_flow_i), .ack_o(ack_o),
    .data_o(data_o), .valid_o(valid_o), .ack_i(ack_i), .resolve_branch_i(resolve_branch_i),
    .full_o(full_o), .empty_o(empty_o), .usage_o(usage_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [63:0] d, input logic c,
                              input logic ak, input logic rs, input logic fl, input logic fu,
                              input logic ev, input logic ea, input logic [2:0] eu);
    vec_t v;
    v.vld = vld; v.d = d; v.c = c; v.ak = ak; v.rs = rs; v.fl = fl; v.fu = fu;
    v.ev = ev; v.ea = ea; v.eu = eu;
    return v;
  endfunction

  task automatic drive_idle();
    valid_i = 0; data_i = '0; is_ctrl_flow_i = 0; ack_i = 0;
    resolve_branch_i = 0; flush_i = 0; flush_unissued_i = 0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk_i);
    valid_i = v.vld; data_i = v.d; is_ctrl_flow_i = v.c; ack_i = v.ak;
    resolve_branch_i = v.rs; flush_i = v.fl; flush_unissued_i = v.fu;
    #1;
    check($sformatf("valid_o[%0d]", idx), {63'd0, valid_o}, {63'd0, v.ev});
    check($sformatf("ack_o[%0d]", idx), {63'd0, ack_o}, {63'd0, v.ea});
    check($sformatf("usage_o[%0d]", idx), {61'd0, usage_o}, {61'd0, v.eu});
    check($sformatf("full_o[%0d]", idx), {63'd0, full_o}, {63'd0, (v.eu == 3'd4)});
    check($sformatf("empty_o[%0d]", idx), {63'd0, empty_o}, {63'd0, (v.eu == 3'd0)});
    if (v.ev) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL data_o[%0d]: got %0h expected nothing queued", idx, data_o);
      end else begin
        check($sformatf("data_o[%0d]", idx), data_o, exp_q[0]);
        if (v.ak) void'(exp_q.pop_front());
      end
    end
    if (v.vld && v.ea) exp_q.push_back(v.d);
    if (v.fl || v.fu) exp_q.delete();
  endtask

  initial begin
    drive_idle();
    rst_ni = 0;
    #12;
    check("reset valid_o", {63'd0, valid_o}, 64'd0);
    check("reset empty_o", {63'd0, empty_o}, 64'd1);
    check("reset full_o", {63'd0, full_o}, 64'd0);
    check("reset usage_o", {61'd0, usage_o}, 64'd0);
    check("reset ack_o", {63'd0, ack_o}, 64'd1);
    @(negedge clk_i);
    rst_ni = 1;

`ifdef ISSUE_BUFFER_BYPASS_EN
    @(negedge clk_i);
    valid_i = 1; data_i = 64'h77; ack_i = 1;
    #1;
    check("bypass data_o", data_o, 64'h77);
    check("bypass valid_o", {63'd0, valid_o}, 64'd1);
    @(negedge clk_i);
    drive_idle();
    #1;
    check("bypass usage_o", {61'd0, usage_o}, 64'd0);
    check("bypass empty_o", {63'd0, empty_o}, 64'd1);
`else
    // fill to full, reject fifth, drain in order
    tbl.push_back(mk(1, 64'h11, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 64'h22, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 64'h33, 0, 0, 0, 0, 0, 1, 1, 2));
    tbl.push_back(mk(1, 64'h44, 0, 0, 0, 0, 0, 1, 1, 3));
    tbl.push_back(mk(1, 64'h55, 0, 0, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 1, 1, 3));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 1, 1, 2));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 0, 1, 0));
    // back-to-back streaming, pointers wrap repeatedly
    tbl.push_back(mk(1, 64'h100, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 1; i < 12; i++)
      tbl.push_back(mk(1, 64'h100 + 64'(i), 0, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 64'h0, 0, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 64'h0, 0, 1, 0, 0, 0, 0, 1, 0));
    // branch lock and resolve
    tbl.push_back(mk(1, 64'hA0, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 64'hB0, 0, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 64'h0,  0, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 64'h0,  0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 64'h0,  0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 0, 1, 0));
    // partial flush keeps lock, full flush clears it
    tbl.push_back(mk(1, 64'hC0, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 64'hC1, 0, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 64'hC2, 0, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 64'hC3, 0, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(1, 64'hEE, 0, 1, 0, 0, 1, 0, 0, 3));
    tbl.push_back(mk(1, 64'hD0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 64'hEF, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 64'hD1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
`endif

    // asynchronous reset in the middle of a cycle with two entries held
    @(negedge clk_i);
    drive_idle();
    valid_i = 1; data_i = 64'hE1;
    @(negedge clk_i);
    data_i = 64'hE2;
    @(negedge clk_i);
    drive_idle();
    #1;
    check("pre-reset usage_o", {61'd0, usage_o}, 64'd2);
    #1;
    rst_ni = 0;
    #1;
    check("async reset valid_o", {63'd0, valid_o}, 64'd0);
    check("async reset empty_o", {63'd0, empty_o}, 64'd1);
    check("async reset usage_o", {61'd0, usage_o}, 64'd0);
    check("async reset ack_o", {63'd0, ack_o}, 64'd1);
    @(negedge clk_i);
    rst_ni = 1;
    exp_q.delete();

`ifndef ISSUE_BUFFER_BYPASS_EN
    // stale entries must not reappear after reset
    apply(mk(1, 64'hF1, 0, 0, 0, 0, 0, 0, 1, 0), 1000);
    apply(mk(0, 64'h0,  0, 1, 0, 0, 0, 1, 1, 1), 1001);
    apply(mk(0, 64'h0,  0, 0, 0, 0, 0, 0, 1, 0), 1002);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
